// File: rtl/tlc_pkg.sv
// Shared types and lamp encodings for the highway/farm-road traffic-light controller.
package tlc_pkg;

  typedef enum logic [2:0] {
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S7 = 3'd7
  } state_t;

  localparam int unsigned LED_BUSY     = 7;
  localparam int unsigned LED_H_RED    = 6;
  localparam int unsigned LED_H_GREEN  = 5;
  localparam int unsigned LED_H_YELLOW = 4;
  localparam int unsigned LED_CLEAR    = 3;
  localparam int unsigned LED_F_RED    = 2;
  localparam int unsigned LED_F_YELLOW = 1;
  localparam int unsigned LED_F_GREEN  = 0;

  localparam logic [6:0] LAMP_S1 = 7'((1 << LED_H_GREEN)  | (1 << LED_F_RED));
  localparam logic [6:0] LAMP_S2 = 7'((1 << LED_H_YELLOW) | (1 << LED_F_RED));
  localparam logic [6:0] LAMP_S3 = 7'((1 << LED_H_RED)    | (1 << LED_F_GREEN));
  localparam logic [6:0] LAMP_S4 = LAMP_S1;
  localparam logic [6:0] LAMP_S5 = 7'((1 << LED_H_RED)    | (1 << LED_F_YELLOW));
  localparam logic [6:0] LAMP_S6 = 7'((1 << LED_CLEAR)    | (1 << LED_F_RED));
  localparam logic [6:0] LAMP_S7 = LAMP_S6;

  localparam logic [7:0] LED_RESET = {1'b0, LAMP_S1};

  function automatic logic [7:0] led_for(state_t s);
    logic [7:0] l;
    l = '0;
    case (s)
      S1:      l[6:0] = LAMP_S1;
      S2:      l[6:0] = LAMP_S2;
      S3:      l[6:0] = LAMP_S3;
      S4:      l[6:0] = LAMP_S4;
      S5:      l[6:0] = LAMP_S5;
      S6:      l[6:0] = LAMP_S6;
      S7:      l[6:0] = LAMP_S7;
      default: l[6:0] = LAMP_S1;
    endcase
    l[LED_BUSY] = (s != S1);
    return l;
  endfunction

endpackage

// File: rtl/tlc_sync.sv
// STAGES-flop level synchronizer for an asynchronous sensor input; clears to 0 on reset.
module tlc_sync #(
  parameter int unsigned STAGES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/tlc_controller.sv
// Highway/farm-road traffic-light FSM with dwell counter and registered lamp bus.
// Optional sticky request flags: define TLC_REQ_LATCH_EN.
module tlc_controller
  import tlc_pkg::*;
#(
  parameter int unsigned STATE_CYCLES = 1,
  parameter int unsigned SYNC_STAGES  = 1
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       FS,
  input  logic       HS,
  output logic [7:0] LED
);

  state_t     state;
  state_t     state_next;
  logic [7:0] dwell;
  logic       dwell_done;
  logic       fs_s;
  logic       hs_s;
  logic       req_f;
  logic       req_h;
  logic [7:0] led_next;

  tlc_sync #(.STAGES(SYNC_STAGES)) u_sync_fs (
    .clk   (MCLK),
    .rst_n (RESET),
    .d     (FS),
    .q     (fs_s)
  );

  tlc_sync #(.STAGES(SYNC_STAGES)) u_sync_hs (
    .clk   (MCLK),
    .rst_n (RESET),
    .d     (HS),
    .q     (hs_s)
  );

`ifdef TLC_REQ_LATCH_EN
  logic pend_f;
  logic pend_h;

  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      pend_f <= 1'b0;
      pend_h <= 1'b0;
    end else begin
      pend_h <= (pend_h | hs_s) & ~((state != S2) && (state_next == S2));
      pend_f <= (pend_f | fs_s) & ~((state != S3) && (state_next == S3));
    end
  end

  // OR-ing the live level keeps the level-mode latency; the flag only extends it.
  assign req_h = pend_h | hs_s;
  assign req_f = pend_f | fs_s;
`else
  assign req_h = hs_s;
  assign req_f = fs_s;
`endif

  assign dwell_done = (dwell == 8'(STATE_CYCLES - 1));

  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      state <= S1;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S1: begin
        if (req_h) begin
          state_next = S2;
        end else if (req_f) begin
          state_next = S3;
        end
      end
      S2: if (dwell_done) state_next = S4;
      S3: if (dwell_done) state_next = S5;
      S4: if (dwell_done) state_next = req_f ? S3 : S6;
      S5: if (dwell_done) state_next = S7;
      S6: if (dwell_done) state_next = S1;
      S7: if (dwell_done) state_next = S1;
      default: state_next = S1;
    endcase
  end

  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      dwell <= '0;
    end else if (state_next != state) begin
      dwell <= '0;
    end else if ((state != S1) && !dwell_done) begin
      dwell <= dwell + 8'd1;
    end
  end

  always_comb begin
    led_next = led_for(state_next);
  end

  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      LED <= LED_RESET;
    end else begin
      LED <= led_next;
    end
  end

endmodule

// File: tb/tb_tlc_controller.sv
// Scoreboard bench for tlc_controller: default instance plus a STATE_CYCLES=3 instance.
module tb_tlc_controller;

  localparam logic [7:0] L_S1 = 8'h24;
  localparam logic [7:0] L_S2 = 8'h94;
  localparam logic [7:0] L_S3 = 8'hC1;
  localparam logic [7:0] L_S4 = 8'hA4;
  localparam logic [7:0] L_S5 = 8'hC2;
  localparam logic [7:0] L_CL = 8'h8C;

  logic       MCLK = 1'b0;
  logic       RESET = 1'b1;
  logic       FS = 1'b0;
  logic       HS = 1'b0;
  logic       FS3 = 1'b0;
  logic       HS3 = 1'b0;
  logic [7:0] LED;
  logic [7:0] LED3;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    bit         sel;
    logic [7:0] exp;
    string      tag;
  } sb_item_t;

  sb_item_t sb[$];

  tlc_controller dut (
    .MCLK  (MCLK),
    .RESET (RESET),
    .FS    (FS),
    .HS    (HS),
    .LED   (LED)
  );

  tlc_controller #(.STATE_CYCLES(3), .SYNC_STAGES(1)) dut3 (
    .MCLK  (MCLK),
    .RESET (RESET),
    .FS    (FS3),
    .HS    (HS3),
    .LED   (LED3)
  );

  always #5 MCLK = ~MCLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: LED=%h required %h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    sb_item_t it;
    if (sb.size() > 0) begin
      it = sb.pop_front();
      check(it.tag, it.sel ? LED3 : LED, it.exp);
    end
  endtask

  // Drive one mid-period vector and queue the LED expected at the following negedge.
  task automatic cyc(input bit sel, input bit f, input bit h, input logic [7:0] e, input string tag);
    @(negedge MCLK);
    drain();
    if (sel) begin
      FS3 = f; HS3 = h; FS = 1'b0; HS = 1'b0;
    end else begin
      FS = f; HS = h; FS3 = 1'b0; HS3 = 1'b0;
    end
    sb.push_back('{sel, e, tag});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 RESET = 1'b0;
    #2;
    check("reset_init", LED, L_S1);
    check("reset_init3", LED3, L_S1);
    @(negedge MCLK);
    @(negedge MCLK);
    RESET = 1'b1;
    cyc(0, 0, 0, L_S1, "idle");
    cyc(0, 0, 0, L_S1, "idle");

`ifndef TLC_REQ_LATCH_EN
    // FS alone: S3, S5, S7, S1
    cyc(0, 1, 0, L_S1, "fs_sync");
    cyc(0, 1, 0, L_S3, "fs_s3");
    cyc(0, 1, 0, L_S5, "fs_s5");
    cyc(0, 0, 0, L_CL, "fs_s7");
    cyc(0, 0, 0, L_S1, "fs_s1");
    cyc(0, 0, 0, L_S1, "fs_idle");

    // HS alone: S2, S4, S6, S1
    cyc(0, 0, 1, L_S1, "hs_sync");
    cyc(0, 0, 1, L_S2, "hs_s2");
    cyc(0, 0, 1, L_S4, "hs_s4");
    cyc(0, 0, 0, L_CL, "hs_s6");
    cyc(0, 0, 0, L_S1, "hs_s1");
    cyc(0, 0, 0, L_S1, "hs_idle");

    // Both, HS wins; FS still up in S4 diverts to S3
    cyc(0, 1, 1, L_S1, "both_sync");
    cyc(0, 1, 1, L_S2, "both_s2");
    cyc(0, 1, 1, L_S4, "both_s4");
    cyc(0, 1, 0, L_S3, "both_s3");
    cyc(0, 1, 0, L_S5, "both_s5");
    cyc(0, 0, 0, L_CL, "both_s7");
    cyc(0, 0, 0, L_S1, "both_s1");
    cyc(0, 0, 0, L_S1, "both_idle");

    // Three-cycle dwell on the second instance
    cyc(1, 1, 0, L_S1, "dw_sync");
    cyc(1, 1, 0, L_S3, "dw_s3a");
    cyc(1, 1, 0, L_S3, "dw_s3b");
    cyc(1, 1, 0, L_S3, "dw_s3c");
    cyc(1, 0, 0, L_S5, "dw_s5a");
    cyc(1, 0, 0, L_S5, "dw_s5b");
    cyc(1, 0, 0, L_S5, "dw_s5c");
    cyc(1, 0, 0, L_CL, "dw_s7a");
    cyc(1, 0, 0, L_CL, "dw_s7b");
    cyc(1, 0, 0, L_CL, "dw_s7c");
    cyc(1, 0, 0, L_S1, "dw_s1");
    cyc(1, 0, 0, L_S1, "dw_idle");
    cyc(0, 0, 0, L_S1, "idle");
`endif

    // Asynchronous reset while in S5
    cyc(0, 1, 0, L_S1, "rst_sync");
    cyc(0, 1, 0, L_S3, "rst_s3");
    cyc(0, 0, 0, L_S5, "rst_s5");
    @(negedge MCLK);
    drain();
    RESET = 1'b0;
    #1;
    check("rst_async", LED, L_S1);
    check("rst_async3", LED3, L_S1);
    #2 RESET = 1'b1;
    cyc(0, 0, 0, L_S1, "rst_hold");
    cyc(0, 0, 0, L_S1, "rst_hold");
    cyc(0, 0, 0, L_S1, "rst_hold");

    // Synchronized FS is high only while in S2
    cyc(0, 0, 1, L_S1, "lt_sync");
    cyc(0, 1, 0, L_S2, "lt_s2");
    cyc(0, 0, 0, L_S4, "lt_s4");
`ifdef TLC_REQ_LATCH_EN
    cyc(0, 0, 0, L_S3, "lt_s3");
    cyc(0, 0, 0, L_S5, "lt_s5");
    cyc(0, 0, 0, L_CL, "lt_s7");
    cyc(0, 0, 0, L_S1, "lt_s1");
`else
    cyc(0, 0, 0, L_CL, "lt_s6");
    cyc(0, 0, 0, L_S1, "lt_s1");
    cyc(0, 0, 0, L_S1, "lt_idle");
    cyc(0, 0, 0, L_S1, "lt_idle");
`endif
    cyc(0, 0, 0, L_S1, "end_idle");
    @(negedge MCLK);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tlc_controller.md
Name: tlc_controller

Overview:
- Traffic-light controller FSM for a highway (H) / farm-road (F) junction.
- Idles in a highway-green state and runs a fixed phase sequence when a car request is present on HS or FS.
- Drives an 8-bit lamp/LED bus directly.
- Top-level leaf block; the clock is the board master clock MCLK.

Parameters:
- STATE_CYCLES, 1: clock cycles spent in every non-idle state (S2..S7) before advancing. Legal range 1..255.
- SYNC_STAGES, 1: number of flops in each request-input synchronizer. Legal range 1..3.

Ports:
- MCLK  in  1  master clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- FS  in  1  farm-road car sensor, level, asynchronous to MCLK.
- HS  in  1  highway car sensor, level, asynchronous to MCLK.
- LED  out  8  lamp drive, registered (encoding below).

Behaviour:
- LED[6:4] = highway lamps {RED, GREEN, YELLOW}.
- LED[3] = clearance indicator: highway lamp dark, hold phase.
- LED[2:0] = farm lamps {RED, YELLOW, GREEN}.
- LED[7] = busy; 1 in every state except S1.
- FS and HS each pass through a SYNC_STAGES-flop synchronizer before use; fs_s and hs_s are the synchronized levels.
- Requests are level-sensitive; nothing is latched (unless the optional feature is enabled).
- LED patterns as LED[6:0]:
  - S1 = 0100100 (H green, F red)
  - S2 = 0010100 (H yellow)
  - S3 = 1000001 (H red, F green)
  - S4 = 0100100 (same pattern as S1)
  - S5 = 1000010 (F yellow)
  - S6 = 0001100 (clear)
  - S7 = 0001100 (clear)
- Transitions are evaluated on each rising edge. A non-idle state advances once its dwell counter reaches STATE_CYCLES-1; the counter clears on every state change.
- S1:
  - hs_s=1 → S2. HS has priority when both requests are high.
  - else fs_s=1 → S3.
  - else stay in S1.
- S2 → S4.
- S4:
  - fs_s=1 → S3.
  - else → S6.
  - hs_s is ignored in S4.
- S3 → S5 → S7 → S1. Requests are ignored in these states.
- S6 → S1.
- Latency with defaults: the request edge is captured by the synchronizer at edge N, and the FSM leaves S1 at edge N+1.
- Each state is then visible for exactly one cycle.
- A request held through S1 re-triggers the sequence after return to S1.
- Reset (RESET=0), including mid-sequence: immediately forces S1, clears the dwell counter and synchronizers, and sets LED=8'b0_0100100.
- Leaving reset: the FSM starts in S1.
- Unused state encodings recover to S1 on the next edge.
- Inputs changing within setup of a clock edge may be captured on that edge or the next; verification drives inputs mid-period.

Optional Feature:
- Macro TLC_REQ_LATCH_EN.
- When defined:
  - Each synchronized request sets a sticky pending flag.
  - The FSM uses the flags instead of fs_s/hs_s.
  - The H flag clears on entering S2.
  - The F flag clears on entering S3.
  - Both flags clear on reset.
  - Single-cycle pulses on FS/HS are therefore served.
- When undefined: purely level-sensitive as above; no flag registers exist.

Decomposition:
- Package tlc_pkg holds:
  - state enum S1..S7
  - LED pattern constants per state
  - lamp bit-index constants
- Sub-module tlc_sync: parameterized SYNC_STAGES synchronizer with async active-low reset to 0, instantiated once per sensor.
- Next-state logic, dwell counter and output register live in tlc_controller.

Test Plan:
- Reset: assert RESET=0 mid-sequence (in S5) → LED=8'h24 immediately; after release, LED stays 8'h24 with FS=HS=0.
- FS=1 for 3 cycles, HS=0 → one cycle after sync, LED[6:0] steps 1000001 → 1000010 → 0001100 → 0100100, one cycle each, LED[7]=1 during S3..S7.
- HS=1 for 3 cycles, FS=0 → LED[6:0] steps 0010100 → 0100100 → 0001100 → 0100100 (S2, S4, S6, S1).
- FS=HS=1 for 3 cycles, then FS=1 alone 2 cycles → S2, S4, S3, S5, S7, S1, i.e. 0010100, 0100100, 1000001, 1000010, 0001100, 0100100.
- STATE_CYCLES=3, FS pulse held 4 cycles → each of S3, S5, S7 lasts exactly 3 cycles.
- TLC_REQ_LATCH_EN defined: 1-cycle FS pulse while in S2 → after S4 the FSM goes to S3, not S6. Undefined: same stimulus → S6.
